// File: rtl/cache_mem_arbiter.sv
// Arbitrates the unified memory among I-fill, D-fill and D-store clients (priority: store > D fill > I fill).
// Latency: grant one cycle after a request is seen in IDLE; a fill holds memory CHUNKS*MEM_LAT cycles, a store MEM_LAT.
// Backpressure: losing or late requesters are held off by level request until the current transaction ends.
module cache_mem_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int CHUNKS  = 8,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    input  logic              mem_data_valid,
    output logic              i_start,
    output logic              d_start,
    output logic              i_data_valid,
    output logic              d_data_valid,
    output logic              i_done,
    output logic              d_done,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              busy
);

    localparam int FILL_LEN = CHUNKS * MEM_LAT;
    localparam int CNT_W    = $clog2(FILL_LEN + 1);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_LEN - 1);
    localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, WRITE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Every transaction ends in IDLE, so a new grant always sees one idle cycle first.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (d_wr_req)   state_nxt = WRITE;
                else if (d_req) state_nxt = D_FILL;
                else if (i_req) state_nxt = I_FILL;
            end
            I_FILL, D_FILL: begin
                if (cnt == FILL_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WRITE: begin
                if (cnt == WR_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        i_start      = 1'b0;
        d_start      = 1'b0;
        i_data_valid = 1'b0;
        d_data_valid = 1'b0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        wr_ack       = 1'b0;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_data_in  = '0;
        busy         = (state != IDLE);
        case (state)
            I_FILL: begin
                mem_en       = 1'b1;
                mem_addr     = i_mem_addr;
                i_start      = (cnt == '0);
                i_data_valid = mem_data_valid;
                i_done       = (cnt == FILL_LAST);
            end
            D_FILL: begin
                mem_en       = 1'b1;
                mem_addr     = d_mem_addr;
                d_start      = (cnt == '0);
                d_data_valid = mem_data_valid;
                d_done       = (cnt == FILL_LAST);
            end
            WRITE: begin
                // The store is issued once; remaining cycles just cover the memory latency.
                if (cnt == '0) begin
                    mem_en      = 1'b1;
                    mem_wr      = 1'b1;
                    mem_addr    = d_wr_addr;
                    mem_data_in = d_wr_data;
                end
                wr_ack = (cnt == WR_LAST);
            end
            default: ;
        endcase
    end

endmodule
